// File: rtl/write_back.sv
`default_nettype none
// ============================================================================
// Module      : write_back
// Description : Final pipeline stage: writeback source select, register-file
//               write port, PC redirect, and UART receive FIFO with stall.
// Revision    : 1.0 - initial release
// ============================================================================
module write_back #(
  parameter int INST_MEM_WIDTH = 2,
  parameter int FIFO_AW        = 2
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      distinct,
  input  logic                      AorF,
  input  logic                      RegWrite,
  input  logic [1:0]                MemtoReg,
  input  logic [1:0]                Branch,
  input  logic                      UARTtoReg,
  input  logic [31:0]               read_data,
  input  logic [31:0]               register_data,
  input  logic [31:0]               alu_result,
  input  logic [4:0]                rdist,
  input  logic [25:0]               inst_index,
  input  logic [INST_MEM_WIDTH-1:0] pc,
  input  logic [INST_MEM_WIDTH-1:0] pc1,
  input  logic [INST_MEM_WIDTH-1:0] pc2,
  input  logic                      uart_rx_valid,
  input  logic [7:0]                uart_rx_data,
  output logic                      uart_rx_ready,
  output logic                      stall,
  output logic                      reg_we_int,
  output logic                      reg_we_float,
  output logic [4:0]                reg_waddr,
  output logic [31:0]               reg_wdata,
  output logic                      pc_redirect,
  output logic [INST_MEM_WIDTH-1:0] pc_target,
  output logic [FIFO_AW:0]          fifo_count,
  output logic [31:0]               retired
);

  localparam int c_DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] c_DEPTH_CNT = c_DEPTH[FIFO_AW:0];

  logic [7:0]                r_mem [c_DEPTH];
  logic [FIFO_AW-1:0]        r_wr_ptr;
  logic [FIFO_AW-1:0]        r_rd_ptr;
  logic [FIFO_AW:0]          r_count;

  logic                      w_in_valid;
  logic                      w_commit;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_redirect;
  logic [31:0]               w_wdata;
  logic [INST_MEM_WIDTH-1:0] w_target;

  // PC and the unused upper operand bits are not needed by this stage
  logic w_unused_bits;
  assign w_unused_bits = ^{pc, inst_index[25:INST_MEM_WIDTH],
                           register_data[31:INST_MEM_WIDTH]};

  assign w_in_valid    = !distinct;
  assign stall         = w_in_valid && UARTtoReg && (r_count == '0);
  assign w_commit      = w_in_valid && !stall;
  assign w_pop         = w_commit && UARTtoReg;
  assign uart_rx_ready = r_count < c_DEPTH_CNT;
  assign w_push        = uart_rx_valid && uart_rx_ready;
  assign fifo_count    = r_count;

  always_comb begin
    w_wdata = alu_result;
    if (UARTtoReg) begin
      w_wdata = {24'd0, r_mem[r_rd_ptr]};
    end else begin
      case (MemtoReg)
        2'b00:   w_wdata = alu_result;
        2'b01:   w_wdata = read_data;
        2'b10:   w_wdata = {{(32-INST_MEM_WIDTH){1'b0}}, pc1};
        default: w_wdata = register_data;
      endcase
    end
  end

  always_comb begin
    w_target   = register_data[INST_MEM_WIDTH-1:0];
    w_redirect = 1'b0;
    case (Branch)
      2'b01: begin
        w_target   = pc2;
        w_redirect = w_commit && (alu_result == 32'd0);
      end
      2'b10: begin
        w_target   = inst_index[INST_MEM_WIDTH-1:0];
        w_redirect = w_commit;
      end
      2'b11: begin
        w_target   = register_data[INST_MEM_WIDTH-1:0];
        w_redirect = w_commit;
      end
      default: w_redirect = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      reg_we_int   <= 1'b0;
      reg_we_float <= 1'b0;
      reg_waddr    <= 5'd0;
      reg_wdata    <= 32'd0;
      pc_redirect  <= 1'b0;
      pc_target    <= '0;
      retired      <= 32'd0;
    end else begin
      // Integer $0 is hardwired; float f0 is a real register
      reg_we_int   <= w_commit && RegWrite && !AorF && (rdist != 5'd0);
      reg_we_float <= w_commit && RegWrite && AorF;
      pc_redirect  <= w_redirect;
      if (w_commit) begin
        reg_waddr <= rdist;
        reg_wdata <= w_wdata;
        retired   <= retired + 32'd1;
      end
      if (w_redirect) begin
        pc_target <= w_target;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
        2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= uart_rx_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_write_back.sv
`default_nettype none
// ============================================================================
// Module      : tb_write_back
// Description : Directed vector table plus UART/FIFO sequences for write_back.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_write_back;

  logic        CLK = 1'b0;
  logic        reset;
  logic        distinct, AorF, RegWrite, UARTtoReg;
  logic [1:0]  MemtoReg, Branch;
  logic [31:0] read_data, register_data, alu_result;
  logic [4:0]  rdist;
  logic [25:0] inst_index;
  logic [1:0]  pc, pc1, pc2;
  logic        uart_rx_valid;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_ready, stall, reg_we_int, reg_we_float, pc_redirect;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata, retired;
  logic [1:0]  pc_target;
  logic [2:0]  fifo_count;

  int n_pass  = 0;
  int n_total = 0;

  write_back #(.INST_MEM_WIDTH(2), .FIFO_AW(2)) dut (
    .CLK(CLK), .reset(reset), .distinct(distinct), .AorF(AorF),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .Branch(Branch),
    .UARTtoReg(UARTtoReg), .read_data(read_data), .register_data(register_data),
    .alu_result(alu_result), .rdist(rdist), .inst_index(inst_index),
    .pc(pc), .pc1(pc1), .pc2(pc2), .uart_rx_valid(uart_rx_valid),
    .uart_rx_data(uart_rx_data), .uart_rx_ready(uart_rx_ready), .stall(stall),
    .reg_we_int(reg_we_int), .reg_we_float(reg_we_float), .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .fifo_count(fifo_count), .retired(retired)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        distinct, aorf, regwrite;
    logic [1:0]  memtoreg, branch;
    logic [31:0] alu, rdata, regdata;
    logic [4:0]  rdist;
    logic [25:0] inst;
    logic [1:0]  pc1, pc2;
    logic        e_we_int, e_we_float;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_redir;
    logic [1:0]  e_target;
    logic [31:0] e_retired;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bubble();
    distinct = 1'b1; AorF = 1'b0; RegWrite = 1'b0; MemtoReg = 2'b00;
    Branch = 2'b00; UARTtoReg = 1'b0; read_data = 32'd0; register_data = 32'd0;
    alu_result = 32'd0; rdist = 5'd0; inst_index = 26'd0; pc = 2'd0;
    pc1 = 2'd0; pc2 = 2'd0; uart_rx_valid = 1'b0; uart_rx_data = 8'd0;
  endtask

  task automatic uart_read(input logic af, input logic [4:0] rd);
    distinct = 1'b0; UARTtoReg = 1'b1; RegWrite = 1'b1; AorF = af; rdist = rd;
    MemtoReg = 2'b00; Branch = 2'b00;
  endtask

  initial begin
    // distinct, aorf, regwr, m2r, br, alu, rdata, regdata, rdist, inst, pc1, pc2,
    // we_int, we_float, waddr, wdata, redir, target, retired
    vecs[0]  = '{1'b0,1'b0,1'b1,2'b00,2'b00,32'h12345678,32'h0,32'h0,5'd5,26'h0,2'd0,2'd0,
                 1'b1,1'b0,5'd5,32'h12345678,1'b0,2'd0,32'd1};
    vecs[1]  = '{1'b0,1'b0,1'b1,2'b00,2'b00,32'h12345678,32'h0,32'h0,5'd0,26'h0,2'd0,2'd0,
                 1'b0,1'b0,5'd0,32'h12345678,1'b0,2'd0,32'd2};
    vecs[2]  = '{1'b0,1'b1,1'b1,2'b00,2'b00,32'h12345678,32'h0,32'h0,5'd0,26'h0,2'd0,2'd0,
                 1'b0,1'b1,5'd0,32'h12345678,1'b0,2'd0,32'd3};
    vecs[3]  = '{1'b0,1'b0,1'b1,2'b01,2'b00,32'h0,32'hDEADBEEF,32'h0,5'd7,26'h0,2'd0,2'd0,
                 1'b1,1'b0,5'd7,32'hDEADBEEF,1'b0,2'd0,32'd4};
    vecs[4]  = '{1'b0,1'b0,1'b1,2'b10,2'b00,32'h0,32'h0,32'h0,5'd31,26'h0,2'd3,2'd0,
                 1'b1,1'b0,5'd31,32'h3,1'b0,2'd0,32'd5};
    vecs[5]  = '{1'b0,1'b1,1'b1,2'b11,2'b00,32'h0,32'h0,32'hCAFEF00D,5'd1,26'h0,2'd0,2'd0,
                 1'b0,1'b1,5'd1,32'hCAFEF00D,1'b0,2'd0,32'd6};
    vecs[6]  = '{1'b0,1'b0,1'b0,2'b00,2'b01,32'h0,32'h0,32'h0,5'd3,26'h0,2'd0,2'd2,
                 1'b0,1'b0,5'd3,32'h0,1'b1,2'd2,32'd7};
    vecs[7]  = '{1'b0,1'b0,1'b0,2'b00,2'b01,32'h1,32'h0,32'h0,5'd3,26'h0,2'd0,2'd1,
                 1'b0,1'b0,5'd3,32'h1,1'b0,2'd2,32'd8};
    vecs[8]  = '{1'b0,1'b0,1'b0,2'b00,2'b11,32'h5,32'h0,32'h3,5'd3,26'h0,2'd0,2'd0,
                 1'b0,1'b0,5'd3,32'h5,1'b1,2'd3,32'd9};
    vecs[9]  = '{1'b0,1'b0,1'b0,2'b00,2'b10,32'h9,32'h0,32'h0,5'd3,26'h3FFFFF1,2'd0,2'd0,
                 1'b0,1'b0,5'd3,32'h9,1'b1,2'd1,32'd10};
    vecs[10] = '{1'b1,1'b0,1'b1,2'b00,2'b10,32'hFFFFFFFF,32'h0,32'h0,5'd9,26'h2,2'd0,2'd0,
                 1'b0,1'b0,5'd3,32'h9,1'b0,2'd1,32'd10};
    vecs[11] = '{1'b0,1'b0,1'b1,2'b00,2'b00,32'h1,32'h0,32'h0,5'd4,26'h0,2'd0,2'd0,
                 1'b1,1'b0,5'd4,32'h1,1'b0,2'd1,32'd11};

    // Reset with random inputs
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      distinct = 1'($urandom); AorF = 1'($urandom); RegWrite = 1'($urandom);
      MemtoReg = 2'($urandom); Branch = 2'($urandom); UARTtoReg = 1'($urandom);
      read_data = $urandom; register_data = $urandom; alu_result = $urandom;
      rdist = 5'($urandom); inst_index = 26'($urandom); pc = 2'($urandom);
      pc1 = 2'($urandom); pc2 = 2'($urandom); uart_rx_valid = 1'($urandom);
      uart_rx_data = 8'($urandom);
      tick();
    end
    check("rst_we_int", {31'd0, reg_we_int}, 32'd0);
    check("rst_we_float", {31'd0, reg_we_float}, 32'd0);
    check("rst_waddr", {27'd0, reg_waddr}, 32'd0);
    check("rst_wdata", reg_wdata, 32'd0);
    check("rst_redirect", {31'd0, pc_redirect}, 32'd0);
    check("rst_target", {30'd0, pc_target}, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_ready", {31'd0, uart_rx_ready}, 32'd1);
    @(negedge CLK);
    reset = 1'b0;
    bubble();
    #1;
    check("rst_stall_bubble", {31'd0, stall}, 32'd0);

    // Vector table
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      bubble();
      distinct = vecs[i].distinct; AorF = vecs[i].aorf; RegWrite = vecs[i].regwrite;
      MemtoReg = vecs[i].memtoreg; Branch = vecs[i].branch; alu_result = vecs[i].alu;
      read_data = vecs[i].rdata; register_data = vecs[i].regdata; rdist = vecs[i].rdist;
      inst_index = vecs[i].inst; pc1 = vecs[i].pc1; pc2 = vecs[i].pc2;
      tick();
      check($sformatf("v%0d_we_int", i), {31'd0, reg_we_int}, {31'd0, vecs[i].e_we_int});
      check($sformatf("v%0d_we_float", i), {31'd0, reg_we_float}, {31'd0, vecs[i].e_we_float});
      check($sformatf("v%0d_waddr", i), {27'd0, reg_waddr}, {27'd0, vecs[i].e_waddr});
      check($sformatf("v%0d_wdata", i), reg_wdata, vecs[i].e_wdata);
      check($sformatf("v%0d_redirect", i), {31'd0, pc_redirect}, {31'd0, vecs[i].e_redir});
      check($sformatf("v%0d_target", i), {30'd0, pc_target}, {30'd0, vecs[i].e_target});
      check($sformatf("v%0d_retired", i), retired, vecs[i].e_retired);
    end

    // UART read against empty FIFO stalls
    @(negedge CLK);
    bubble();
    uart_read(1'b0, 5'd6);
    #1;
    check("stall_comb", {31'd0, stall}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_hold", {31'd0, stall}, 32'd1);
      check("stall_no_we", {31'd0, reg_we_int}, 32'd0);
      check("stall_retired", retired, 32'd11);
    end
    @(negedge CLK);
    uart_rx_valid = 1'b1; uart_rx_data = 8'hA5;
    #1;
    check("push_edge_stall", {31'd0, stall}, 32'd1);
    tick();
    check("push_count", {29'd0, fifo_count}, 32'd1);
    check("push_stall_drop", {31'd0, stall}, 32'd0);
    check("push_no_commit", retired, 32'd11);
    @(negedge CLK);
    uart_rx_valid = 1'b0;
    tick();
    check("uart_we", {31'd0, reg_we_int}, 32'd1);
    check("uart_waddr", {27'd0, reg_waddr}, 32'd6);
    check("uart_wdata", reg_wdata, 32'h000000A5);
    check("uart_retired", retired, 32'd12);
    check("uart_count", {29'd0, fifo_count}, 32'd0);

    // Fill past capacity
    @(negedge CLK);
    bubble();
    for (int i = 1; i <= 5; i++) begin
      uart_rx_valid = 1'b1; uart_rx_data = 8'(i);
      #1;
      check($sformatf("fill%0d_ready", i), {31'd0, uart_rx_ready}, (i <= 4) ? 32'd1 : 32'd0);
      @(negedge CLK);
    end
    uart_rx_valid = 1'b0;
    #1;
    check("full_count", {29'd0, fifo_count}, 32'd4);
    check("full_ready", {31'd0, uart_rx_ready}, 32'd0);

    // Drain in order on consecutive edges
    @(negedge CLK);
    uart_read(1'b1, 5'd2);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("drain%0d_wdata", i), reg_wdata, 32'(i));
      check($sformatf("drain%0d_we_float", i), {31'd0, reg_we_float}, 32'd1);
      check($sformatf("drain%0d_count", i), {29'd0, fifo_count}, 32'(4 - i));
      check($sformatf("drain%0d_retired", i), retired, 32'(12 + i));
    end

    // Simultaneous push/pop at count 2
    @(negedge CLK);
    bubble();
    uart_rx_valid = 1'b1; uart_rx_data = 8'h11;
    @(negedge CLK);
    uart_rx_data = 8'h22;
    @(negedge CLK);
    uart_rx_data = 8'h33;
    uart_read(1'b0, 5'd8);
    #1;
    check("pp_pre_count", {29'd0, fifo_count}, 32'd2);
    tick();
    check("pp_count", {29'd0, fifo_count}, 32'd2);
    check("pp_wdata", reg_wdata, 32'h11);
    check("pp_retired", retired, 32'd17);
    @(negedge CLK);
    uart_rx_valid = 1'b0;
    tick();
    check("pp_next_wdata", reg_wdata, 32'h22);
    tick();
    check("pp_last_wdata", reg_wdata, 32'h33);
    check("pp_empty", {29'd0, fifo_count}, 32'd0);

    // Reset arrives on the edge that would commit a freshly pushed byte
    tick();
    check("rs_stall", {31'd0, stall}, 32'd1);
    @(negedge CLK);
    uart_rx_valid = 1'b1; uart_rx_data = 8'h44;
    tick();
    check("rs_count1", {29'd0, fifo_count}, 32'd1);
    @(negedge CLK);
    uart_rx_valid = 1'b0;
    reset = 1'b1;
    tick();
    check("rs_count0", {29'd0, fifo_count}, 32'd0);
    check("rs_no_we", {31'd0, reg_we_int}, 32'd0);
    check("rs_wdata", reg_wdata, 32'd0);
    check("rs_retired", retired, 32'd0);
    @(negedge CLK);
    reset = 1'b0;
    tick();
    check("rs_after_we", {31'd0, reg_we_int}, 32'd0);
    check("rs_after_stall", {31'd0, stall}, 32'd1);
    check("rs_after_ready", {31'd0, uart_rx_ready}, 32'd1);
    @(negedge CLK);
    bubble();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/write_back.md
# write_back

Final stage of the integer/float pipeline, directly downstream of `memory_access`. It consumes that stage's registered outputs and selects the writeback value from ALU result, load data, link PC, store-operand bypass, or a UART receive byte. It drives one registered register-file write port steered to the integer or float file, and a registered PC-redirect pulse for branches and jumps. It owns the UART receive FIFO and stalls the pipeline when a UART read finds the FIFO empty.

## Interface
- `INST_MEM_WIDTH`, 2, instruction address width; must equal the upstream value.
- `FIFO_AW`, 2, log2 of UART RX FIFO depth (default depth 4).
- `CLK` in 1: clock; all state updates on the rising edge.
- `reset` in 1: reset, synchronous, active-high; clock CLK.
- `distinct` in 1: 1 = bubble, 0 = valid instruction.
- `AorF` in 1: 0 = integer register file, 1 = float register file.
- `RegWrite` in 1: instruction writes a register.
- `MemtoReg` in 2: writeback source select; 00 alu_result, 01 read_data, 10 pc1 zero-extended, 11 register_data.
- `Branch` in 2: 00 none; 01 branch to `pc2` if alu_result==0; 10 jump to inst_index[INST_MEM_WIDTH-1:0]; 11 jump to register_data[INST_MEM_WIDTH-1:0].
- `UARTtoReg` in 1: write value is the FIFO head byte, zero-extended; overrides MemtoReg.
- `read_data`, `register_data`, `alu_result` in 32 each: operands from `memory_access`.
- `rdist` in 5: destination register.
- `inst_index` in 26: jump target field.
- `pc`, `pc1`, `pc2` in INST_MEM_WIDTH each: current PC, PC+1, branch target.
- `uart_rx_valid` in 1; `uart_rx_data` in 8: received byte offer.
- `uart_rx_ready` out 1: FIFO can accept a byte.
- `stall` out 1: hold all upstream stages and keep inputs stable.
- `reg_we_int`, `reg_we_float` out 1 each: write enables, one per register file.
- `reg_waddr` out 5; `reg_wdata` out 32: write port.
- `pc_redirect` out 1; `pc_target` out INST_MEM_WIDTH: fetch redirect.
- `fifo_count` out FIFO_AW+1: FIFO occupancy.
- `retired` out 32: committed-instruction counter.

## Operation
- `in_valid = !distinct`.
- `stall = in_valid && UARTtoReg && fifo_count==0`. This is combinational from the registered count and the inputs.
- An instruction commits on a rising edge when `in_valid && !stall`.
- **Commit effects:**
  - `reg_we_int <= RegWrite && !AorF && rdist!=0`. Integer $0 writes are suppressed.
  - `reg_we_float <= RegWrite && AorF`. Float register 0 is writable.
  - `reg_waddr <= rdist`; `reg_wdata <=` the selected source.
  - If UARTtoReg, pop the FIFO head.
  - `retired <= retired+1` (wraps at 2^32).
- **Redirect:** `pc_redirect <= 1` and `pc_target <=` per the Branch encoding on commit when Branch is 10 or 11, or when it is 01 and alu_result==0. Otherwise `pc_redirect <= 0`.
- **No commit:** on any non-commit edge (bubble or stall), `reg_we_*` and `pc_redirect` go to 0; `reg_waddr`, `reg_wdata` and `pc_target` hold.
- **FIFO:** circular buffer with read/write pointers of FIFO_AW bits, wrapping modulo depth.
  - `uart_rx_ready = fifo_count < 2^FIFO_AW`.
  - A push happens when `uart_rx_valid && uart_rx_ready`. The byte is stored at the write pointer.
  - If a push and a pop fall on the same edge, the count is unchanged and both pointers advance.
  - When full, ready is low; there is no push-through even if a pop happens that edge.
  - When empty, a same-edge push does not satisfy a waiting read. The read commits on the next edge.
- **Reset:** all outputs clear on reset (`reg_we_*`=0, `reg_waddr`=0, `reg_wdata`=0, `pc_redirect`=0, `pc_target`=0, `retired`=0). Pointers and count go to 0, so `fifo_count`=0 and `uart_rx_ready`=1. `stall` follows its equation; it is 0 while `distinct`=1.
- **Reset mid-stall:** FIFO contents are discarded and no write is issued.

## Timing
- Latency is one cycle: an input committed at edge N appears on the write port/redirect outputs after edge N, valid during cycle N+1.
- Write enables and `pc_redirect` are single-cycle pulses per committed instruction.
- **Stall:**
  - Asserted in the same cycle a UART read is presented against an empty FIFO.
  - The first byte pushed at edge N lets `stall` drop in cycle N+1; commit happens at edge N+1.
  - Upstream must hold inputs unchanged while `stall`=1.
- The UART byte is accepted on the edge where valid&&ready; `fifo_count` reflects it the following cycle.
- Back-to-back UART reads with k bytes queued commit on k consecutive edges.

## Test plan
- **Reset:** assert reset 2 cycles with random inputs -> all outputs 0, `uart_rx_ready`=1, `retired`=0.
- **Source mux and register files:**
  - alu_result=0x12345678, rdist=5, AorF=0, RegWrite=1, MemtoReg=00 -> next cycle `reg_we_int`=1, `reg_waddr`=5, `reg_wdata`=0x12345678, `retired`=1.
  - Repeat with rdist=0 -> no write.
  - Repeat with AorF=1, rdist=0 -> `reg_we_float`=1.
- **Redirects:**
  - Branch=01, alu_result=0, pc2=2 -> `pc_redirect`=1, `pc_target`=2.
  - Branch=01, alu_result=1 -> no redirect.
  - Branch=11, register_data=3 -> `pc_target`=3.
- **UART stall:**
  - UART read with empty FIFO for 5 cycles -> `stall`=1, no write, `retired` unchanged.
  - Push 0xA5 -> next cycle `stall`=0; after the following edge `reg_wdata`=0x000000A5.
- **FIFO full and order:**
  - Push 0x01..0x05 continuously -> 4 accepted, `uart_rx_ready`=0 at count 4.
  - Four UART reads -> data 0x01,0x02,0x03,0x04 in order, pointers wrap correctly.
- **Simultaneous push/pop and reset mid-stall:**
  - Push+pop on the same edge at count 2 -> count stays 2.
  - Reset during stall -> FIFO empty, no write issued.
